// File: rtl/game_overseer.sv
// Game-rule engine: per-frame torpedo/target collision capture, launch strobes,
// IDLE/START/PLAY/WON/LOST FSM, end-of-game timer and saturating score.
// Optional attract mode via `define GAME_OVERSEER_AUTO_RESTART_EN.
module game_overseer #(
  parameter int unsigned N_TARGETS   = 4,
  parameter int unsigned SCORE_WIDTH = 8,
  parameter int unsigned TIMER_WIDTH = 24,
  parameter logic [TIMER_WIDTH-1:0] END_TIME = TIMER_WIDTH'(24'hf00000)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   launch,
  input  logic                   frame_start,
  input  logic                   display_on,
  input  logic [N_TARGETS-1:0]   target_en,
  input  logic [N_TARGETS-1:0]   target_out,
  input  logic                   torpedo_en,
  input  logic                   torpedo_out,
  output logic [N_TARGETS-1:0]   target_write,
  output logic                   torpedo_write,
  output logic                   game_won,
  output logic                   timer_running,
  output logic [N_TARGETS-1:0]   hit_mask,
  output logic [SCORE_WIDTH-1:0] score
);

  localparam int unsigned POP_W = $clog2(N_TARGETS + 1);
  localparam int unsigned SUM_W = ((SCORE_WIDTH > POP_W) ? SCORE_WIDTH : POP_W) + 1;
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_PLAY, S_WON, S_LOST} state_t;

  state_t                 state, state_nxt;
  logic                   launch_q, frame_start_q;
  logic [N_TARGETS-1:0]   pending, pending_nxt, hit_mask_nxt, target_write_nxt;
  logic [TIMER_WIDTH-1:0] timer, timer_nxt;
  logic [SCORE_WIDTH-1:0] score_nxt;
  logic                   torpedo_write_nxt, game_won_nxt, timer_running_nxt;
  logic                   restart_q, restart_nxt;
  logic [N_TARGETS-1:0]   hit_term;
  logic [POP_W-1:0]       pop;
  logic [SUM_W-1:0]       sum;
  logic                   launch_rise;

  assign hit_term    = {N_TARGETS{display_on & torpedo_en}} & target_en;
  assign launch_rise = launch & ~launch_q;

  // Hit count of the latched frame and the unclamped new score.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_TARGETS; i++) pop = pop + POP_W'(hit_mask[i]);
    sum = SUM_W'(score) + SUM_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    pending_nxt       = frame_start ? hit_term : (pending | hit_term);
    hit_mask_nxt      = frame_start ? pending : hit_mask;
    timer_nxt         = timer;
    score_nxt         = score;
    target_write_nxt  = '0;
    torpedo_write_nxt = 1'b0;
    restart_nxt       = restart_q;
    case (state)
      S_IDLE: begin
`ifdef GAME_OVERSEER_AUTO_RESTART_EN
        if (launch_rise || restart_q) begin
`else
        if (launch_rise) begin
`endif
          state_nxt         = S_START;
          target_write_nxt  = '1;
          torpedo_write_nxt = 1'b1;
          restart_nxt       = 1'b0;
        end
      end
      S_START: begin
        pending_nxt  = '0;
        hit_mask_nxt = '0;
        state_nxt    = S_PLAY;
      end
      // Decide only on the cycle after frame_start, when hit_mask is fresh.
      S_PLAY: begin
        if (frame_start_q) begin
          if (|hit_mask) begin
            state_nxt = S_WON;
            timer_nxt = END_TIME;
            score_nxt = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_WIDTH'(sum);
          end else if (torpedo_out) begin
            state_nxt = S_LOST;
            timer_nxt = END_TIME;
          end else begin
            target_write_nxt = target_out;
          end
        end
      end
      S_WON, S_LOST: begin
        if (timer <= TIMER_WIDTH'(1)) begin
          state_nxt   = S_IDLE;
          timer_nxt   = '0;
          restart_nxt = 1'b1;
        end else begin
          timer_nxt = timer - TIMER_WIDTH'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    game_won_nxt      = (state_nxt == S_WON);
    timer_running_nxt = (timer_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      launch_q      <= 1'b0;
      frame_start_q <= 1'b0;
      pending       <= '0;
      hit_mask      <= '0;
      timer         <= '0;
      score         <= '0;
      target_write  <= '0;
      torpedo_write <= 1'b0;
      game_won      <= 1'b0;
      timer_running <= 1'b0;
      restart_q     <= 1'b0;
    end else begin
      launch_q      <= launch;
      frame_start_q <= frame_start;
      pending       <= pending_nxt;
      hit_mask      <= hit_mask_nxt;
      timer         <= timer_nxt;
      score         <= score_nxt;
      target_write  <= target_write_nxt;
      torpedo_write <= torpedo_write_nxt;
      game_won      <= game_won_nxt;
      timer_running <= timer_running_nxt;
      restart_q     <= restart_nxt;
    end
  end

endmodule

// File: tb/tb_game_overseer.sv
// Directed bench for game_overseer (N_TARGETS=4, SCORE_WIDTH=4, END_TIME=16).
module tb_game_overseer;

  logic       clk = 1'b0;
  logic       reset;
  logic       launch, frame_start, display_on, torpedo_en, torpedo_out;
  logic [3:0] target_en, target_out;
  logic [3:0] target_write, hit_mask, score;
  logic       torpedo_write, game_won, timer_running;

  int checks = 0;
  int errors = 0;

  game_overseer #(
    .N_TARGETS(4), .SCORE_WIDTH(4), .TIMER_WIDTH(24), .END_TIME(24'd16)
  ) dut (
    .clk(clk), .reset(reset), .launch(launch), .frame_start(frame_start),
    .display_on(display_on), .target_en(target_en), .target_out(target_out),
    .torpedo_en(torpedo_en), .torpedo_out(torpedo_out),
    .target_write(target_write), .torpedo_write(torpedo_write),
    .game_won(game_won), .timer_running(timer_running),
    .hit_mask(hit_mask), .score(score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    launch = 1'b0; tick();
    launch = 1'b1; tick();
    launch = 1'b0; tick();
  endtask

  // Start a game, paint one collision pixel on mask, close the frame; ends one cycle into WON.
  task automatic run_hit_game(input logic [3:0] mask);
    start_game();
    display_on = 1'b1; torpedo_en = 1'b1; target_en = mask;
    tick();
    display_on = 1'b0; torpedo_en = 1'b0; target_en = 4'b0000;
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (timer_running && n < 100) begin tick(); n++; end
    checks++;
    if (timer_running !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle timeout: timer_running=%b required 0", timer_running);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; launch = 1'b0; frame_start = 1'b0; display_on = 1'b0;
    torpedo_en = 1'b0; torpedo_out = 1'b0; target_en = '0; target_out = '0;
    repeat (3) tick();
    checks += 6;
    if (target_write !== 4'b0)  begin errors++; $display("FAIL reset target_write: got %b required 0000", target_write); end
    if (torpedo_write !== 1'b0) begin errors++; $display("FAIL reset torpedo_write: got %b required 0", torpedo_write); end
    if (game_won !== 1'b0)      begin errors++; $display("FAIL reset game_won: got %b required 0", game_won); end
    if (timer_running !== 1'b0) begin errors++; $display("FAIL reset timer_running: got %b required 0", timer_running); end
    if (hit_mask !== 4'b0)      begin errors++; $display("FAIL reset hit_mask: got %b required 0000", hit_mask); end
    if (score !== 4'd0)         begin errors++; $display("FAIL reset score: got %0d required 0", score); end
    reset = 1'b1; tick();
  endtask

  task automatic test_start();
    launch = 1'b1; tick();
    checks += 4;
    if (target_write !== 4'b1111) begin errors++; $display("FAIL start target_write: got %b required 1111", target_write); end
    if (torpedo_write !== 1'b1)   begin errors++; $display("FAIL start torpedo_write: got %b required 1", torpedo_write); end
    tick();
    if (target_write !== 4'b0000) begin errors++; $display("FAIL start strobe width target_write: got %b required 0000", target_write); end
    if (torpedo_write !== 1'b0)   begin errors++; $display("FAIL start strobe width torpedo_write: got %b required 0", torpedo_write); end
    launch = 1'b0;
    // Leave this game by losing, so later tests start from IDLE.
    torpedo_out = 1'b1; frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
    torpedo_out = 1'b0;
    wait_idle();
  endtask

  task automatic test_hit_win();
    int n;
    run_hit_game(4'b0100);
    checks += 5;
    if (hit_mask !== 4'b0100) begin errors++; $display("FAIL win hit_mask: got %b required 0100", hit_mask); end
    if (game_won !== 1'b1)    begin errors++; $display("FAIL win game_won: got %b required 1", game_won); end
    if (score !== 4'd1)       begin errors++; $display("FAIL win score: got %0d required 1", score); end
    n = 0;
    while (timer_running && n < 100) begin n++; tick(); end
    if (n !== 16)             begin errors++; $display("FAIL win timer cycles: got %0d required 16", n); end
    if (game_won !== 1'b0)    begin errors++; $display("FAIL win game_won after timer: got %b required 0", game_won); end
  endtask

  task automatic test_priority();
    torpedo_out = 1'b1;
    run_hit_game(4'b1001);
    torpedo_out = 1'b0;
    checks += 2;
    if (game_won !== 1'b1) begin errors++; $display("FAIL priority game_won: got %b required 1", game_won); end
    if (score !== 4'd3)    begin errors++; $display("FAIL priority score: got %0d required 3", score); end
    wait_idle();
  endtask

  task automatic test_relaunch();
    start_game();
    target_out = 4'b0010;
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
    checks += 4;
    if (target_write !== 4'b0010) begin errors++; $display("FAIL relaunch target_write: got %b required 0010", target_write); end
    tick();
    if (target_write !== 4'b0000) begin errors++; $display("FAIL relaunch strobe width: got %b required 0000", target_write); end
    if (game_won !== 1'b0)        begin errors++; $display("FAIL relaunch game_won: got %b required 0", game_won); end
    if (timer_running !== 1'b0)   begin errors++; $display("FAIL relaunch timer_running: got %b required 0", timer_running); end
    target_out = 4'b0000;
  endtask

  task automatic test_lost();
    logic strobed;
    torpedo_out = 1'b1;
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
    torpedo_out = 1'b0;
    checks += 4;
    if (timer_running !== 1'b1) begin errors++; $display("FAIL lost timer_running: got %b required 1", timer_running); end
    if (game_won !== 1'b0)      begin errors++; $display("FAIL lost game_won: got %b required 0", game_won); end
    if (score !== 4'd3)         begin errors++; $display("FAIL lost score: got %0d required 3", score); end
    launch = 1'b1; tick();
    launch = 1'b0; tick();
    wait_idle();
    strobed = 1'b0;
    repeat (4) begin tick(); strobed |= torpedo_write | (|target_write); end
    if (strobed !== 1'b0) begin errors++; $display("FAIL lost launch ignored: strobe seen=%b required 0", strobed); end
  endtask

  task automatic test_saturate();
    run_hit_game(4'b1111); wait_idle();
    run_hit_game(4'b1111); wait_idle();
    run_hit_game(4'b0111);
    checks++;
    if (score !== 4'd14) begin errors++; $display("FAIL saturate pre score: got %0d required 14", score); end
    wait_idle();
    run_hit_game(4'b0101);
    checks += 2;
    if (score !== 4'd15)   begin errors++; $display("FAIL saturate score: got %0d required 15", score); end
    if (game_won !== 1'b1) begin errors++; $display("FAIL saturate game_won: got %b required 1", game_won); end
    // Asynchronous reset in the middle of WON, checked before the next clock edge.
    reset = 1'b0; #1;
    checks += 4;
    if (score !== 4'd0)         begin errors++; $display("FAIL midreset score: got %0d required 0", score); end
    if (game_won !== 1'b0)      begin errors++; $display("FAIL midreset game_won: got %b required 0", game_won); end
    if (timer_running !== 1'b0) begin errors++; $display("FAIL midreset timer_running: got %b required 0", timer_running); end
    if (hit_mask !== 4'b0)      begin errors++; $display("FAIL midreset hit_mask: got %b required 0000", hit_mask); end
    tick();
    reset = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_win();
    test_priority();
    test_relaunch();
    test_lost();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
